instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 49 ++++
 rtl/instr_fetch_fetch_decode.sv | 20 ++
 rtl/instr_fetch.sv | 95 +++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared opcode constants, FSM state type and default PC width
// Purpose: constants and types shared by the fetch unit, its decoder and its interface.
// Contents: PC_W (default PC/ROM address width), OP_HALT / OP_BR / OP_BRB opcodes, state_e.
package instr_fetch_pkg;

  localparam int PC_W = 8;

  // Full-byte halt opcode; branches match on the top five bits only,
  // leaving inst[2:0] as the register holding the branch offset.
  localparam logic [7:0] OP_HALT = 8'b10001000;
  localparam logic [4:0] OP_BR   = 5'b11110;
  localparam logic [4:0] OP_BRB  = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, ROM and datapath signals of the fetch unit
// Purpose: bundles every non-clock/reset signal of instr_fetch.
// Modports:
//   master - the fetch unit: drives address_o, rs_o, inst_valid_o, done_o, retired_o;
//            samples start_i, start_addr_i, inst_i, flag_i, off_i.
//   slave  - the surrounding ROM/datapath/control: the opposite directions.
interface instr_fetch_if #(
  parameter int PC_W  = instr_fetch_pkg::PC_W,
  parameter int CNT_W = 16
);

  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic [PC_W-1:0]  address_o;
  logic [7:0]       inst_i;
  logic             flag_i;
  logic [7:0]       off_i;
  logic [2:0]       rs_o;
  logic             inst_valid_o;
  logic             done_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  start_i,
    input  start_addr_i,
    output address_o,
    input  inst_i,
    input  flag_i,
    input  off_i,
    output rs_o,
    output inst_valid_o,
    output done_o,
    output retired_o
  );

  modport slave (
    output start_i,
    output start_addr_i,
    input  address_o,
    output inst_i,
    output flag_i,
    output off_i,
    input  rs_o,
    input  inst_valid_o,
    input  done_o,
    input  retired_o
  );

endinterface

// File: rtl/instr_fetch_fetch_decode.sv
// rtl/instr_fetch_fetch_decode.sv - combinational opcode classifier for the fetch unit
// Purpose: flags the instruction byte as halt, forward branch or backward branch.
// Ports:
//   i_inst     - ROM data byte
//   o_is_halt  - inst is exactly the halt opcode
//   o_is_br    - inst is a forward branch (flag-conditional)
//   o_is_brb   - inst is a backward branch (flag-conditional)
module fetch_decode (
  input  logic [7:0] i_inst,
  output logic       o_is_halt,
  output logic       o_is_br,
  output logic       o_is_brb
);
  import instr_fetch_pkg::*;

  assign o_is_halt = (i_inst == OP_HALT);
  assign o_is_br   = (i_inst[7:3] == OP_BR);
  assign o_is_brb  = (i_inst[7:3] == OP_BRB);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, next-PC selection and retire counter
// Purpose: sequences a program from start_addr_i until halt, one instruction per cycle,
//          resolving flag-conditional relative branches with no bubble.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - instr_fetch_if.master: start/start address in, ROM address out and data in,
//            flag/offset from the datapath, rs/valid/done/retired out
module instr_fetch #(
  parameter int PC_W  = instr_fetch_pkg::PC_W,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  instr_fetch_if.master bus
);
  import instr_fetch_pkg::*;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_off;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] w_retired_nxt;
  logic             w_is_halt;
  logic             w_is_br;
  logic             w_is_brb;

  fetch_decode u_decode (
    .i_inst    (bus.inst_i),
    .o_is_halt (w_is_halt),
    .o_is_br   (w_is_br),
    .o_is_brb  (w_is_brb)
  );

  // Both the sequential step and the branch targets are relative to PC+1;
  // all sums truncate to PC_W bits so they wrap modulo 2^PC_W.
  assign w_pc_inc = r_pc + 1'b1;
  assign w_off    = PC_W'(bus.off_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start_i) begin
          w_pc_nxt      = bus.start_addr_i;
          w_retired_nxt = '0;
          w_state_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        // start_i is deliberately not looked at here: a running program
        // can only be stopped by halt or reset.
        if (r_retired != '1) begin
          w_retired_nxt = r_retired + 1'b1;
        end
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_br && bus.flag_i) begin
          w_pc_nxt = w_pc_inc + w_off;
        end else if (w_is_brb && bus.flag_i) begin
          w_pc_nxt = w_pc_inc - w_off;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.address_o    = r_pc;
  assign bus.rs_o         = bus.inst_i[2:0];
  assign bus.inst_valid_o = (r_state == ST_RUN);
  assign bus.done_o       = (r_state == ST_HALT);
  assign bus.retired_o    = r_retired;

endmodule
